// File: rtl/cpu_subsys_mem_router_if.sv
// CPU-side and target-side bus bundles for cpu_subsys_mem_router.
// master drives the request, slave returns the response.
interface cpu_subsys_mem_router_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic                  cpu_mem_valid;
    logic                  cpu_mem_ready;
    logic [ADDR_W-1:0]     cpu_mem_addr;
    logic [DATA_W-1:0]     cpu_mem_wdata;
    logic                  cpu_mem_we;
    logic [DATA_W/8-1:0]   cpu_mem_be;
    logic [DATA_W-1:0]     cpu_mem_rdata;
    logic                  cpu_mem_err;

    modport master (
        output cpu_mem_valid, cpu_mem_addr, cpu_mem_wdata, cpu_mem_we, cpu_mem_be,
        input  cpu_mem_ready, cpu_mem_rdata, cpu_mem_err
    );
    modport slave (
        input  cpu_mem_valid, cpu_mem_addr, cpu_mem_wdata, cpu_mem_we, cpu_mem_be,
        output cpu_mem_ready, cpu_mem_rdata, cpu_mem_err
    );
endinterface

interface cpu_subsys_mem_router_tgt_if #(
    parameter int unsigned N_TARGETS = 3,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32
);
    logic [N_TARGETS-1:0]        tgt_mem_valid;
    logic [ADDR_W-1:0]           tgt_mem_addr;
    logic                        tgt_mem_write;
    logic [DATA_W-1:0]           tgt_mem_wdata;
    logic [DATA_W/8-1:0]         tgt_mem_wstrb;
    logic [N_TARGETS*DATA_W-1:0] tgt_mem_rdata;
    logic [N_TARGETS-1:0]        tgt_mem_ready;

    modport master (
        output tgt_mem_valid, tgt_mem_addr, tgt_mem_write, tgt_mem_wdata, tgt_mem_wstrb,
        input  tgt_mem_rdata, tgt_mem_ready
    );
    modport slave (
        input  tgt_mem_valid, tgt_mem_addr, tgt_mem_write, tgt_mem_wdata, tgt_mem_wstrb,
        output tgt_mem_rdata, tgt_mem_ready
    );
endinterface

// File: rtl/cpu_subsys_mem_router.sv
// Routes the CPU memory interface to N_TARGETS address windows, with decode-miss
// and timeout error responses, last-error address and a saturating error count.
module cpu_subsys_mem_router #(
    parameter int unsigned                  N_TARGETS      = 3,
    parameter int unsigned                  ADDR_W         = 32,
    parameter int unsigned                  DATA_W         = 32,
    parameter logic [N_TARGETS*ADDR_W-1:0]  TARGET_BASE    = {32'h8000_0000, 32'h4000_0000, 32'h0000_0000},
    parameter logic [N_TARGETS*ADDR_W-1:0]  TARGET_MASK    = {32'h8000_0000, 32'hC000_0000, 32'hC000_0000},
    parameter int unsigned                  TIMEOUT_CYCLES = 255,
    parameter logic [31:0]                  ERR_RDATA      = 32'hDEAD_BEEF
) (
    input  logic                         sys_clk,
    input  logic                         rst,
    cpu_subsys_mem_router_if.slave       cpu,
    cpu_subsys_mem_router_tgt_if.master  tgt,
    output logic                         err_pulse,
    output logic [ADDR_W-1:0]            err_addr,
    output logic [15:0]                  err_count
);
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned SEL_W  = (N_TARGETS > 1) ? $clog2(N_TARGETS) : 1;
    localparam int unsigned CNT_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [DATA_W-1:0] ERR_RDATA_W = DATA_W'(ERR_RDATA);
    localparam logic [CNT_W-1:0]  CNT_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_RESP, S_ERR} state_t;

    state_t               r_state;
    logic [SEL_W-1:0]     r_sel;
    logic [CNT_W-1:0]     r_cnt;
    logic [ADDR_W-1:0]    r_addr;
    logic [DATA_W-1:0]    r_wdata;
    logic                 r_we;
    logic [STRB_W-1:0]    r_be;
    logic [N_TARGETS-1:0] r_tgt_valid;
    logic                 r_ready;
    logic                 r_err;
    logic [DATA_W-1:0]    r_rdata;
    logic                 r_err_pulse;
    logic [ADDR_W-1:0]    r_err_addr;
    logic [15:0]          r_err_count;

    logic                 w_hit;
    logic [SEL_W-1:0]     w_sel;
    logic [N_TARGETS-1:0] w_onehot;
    logic                 w_sel_ready;
    logic [DATA_W-1:0]    w_sel_rdata;
    logic                 w_timeout;
    logic [15:0]          w_err_count_next;

    // First matching window wins, so lower indices take priority on overlap.
    always_comb begin
        w_hit    = 1'b0;
        w_sel    = '0;
        w_onehot = '0;
        for (int unsigned i = 0; i < N_TARGETS; i++) begin
            if (!w_hit &&
                ((cpu.cpu_mem_addr & TARGET_MASK[i*ADDR_W +: ADDR_W]) ==
                 (TARGET_BASE[i*ADDR_W +: ADDR_W] & TARGET_MASK[i*ADDR_W +: ADDR_W]))) begin
                w_hit       = 1'b1;
                w_sel       = SEL_W'(i);
                w_onehot[i] = 1'b1;
            end
        end
    end

    always_comb begin
        w_sel_ready = 1'b0;
        w_sel_rdata = '0;
        for (int unsigned i = 0; i < N_TARGETS; i++) begin
            if (r_sel == SEL_W'(i)) begin
                w_sel_ready = tgt.tgt_mem_ready[i];
                w_sel_rdata = tgt.tgt_mem_rdata[i*DATA_W +: DATA_W];
            end
        end
    end

    assign w_timeout        = (TIMEOUT_CYCLES != 0) && (r_cnt == CNT_LAST);
    assign w_err_count_next = (r_err_count == 16'hFFFF) ? r_err_count : r_err_count + 16'd1;

    // Response outputs are loaded on the transition into RESP/ERR so they are
    // registered yet visible exactly during that one-cycle state.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_sel       <= '0;
            r_cnt       <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_we        <= 1'b0;
            r_be        <= '0;
            r_tgt_valid <= '0;
            r_ready     <= 1'b0;
            r_err       <= 1'b0;
            r_rdata     <= '0;
            r_err_pulse <= 1'b0;
            r_err_addr  <= '0;
            r_err_count <= '0;
        end else begin
            r_ready     <= 1'b0;
            r_err       <= 1'b0;
            r_err_pulse <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cpu.cpu_mem_valid) begin
                        r_addr  <= cpu.cpu_mem_addr;
                        r_wdata <= cpu.cpu_mem_wdata;
                        r_we    <= cpu.cpu_mem_we;
                        r_be    <= cpu.cpu_mem_be;
                        r_sel   <= w_sel;
                        r_cnt   <= '0;
                        if (w_hit) begin
                            r_tgt_valid <= w_onehot;
                            r_state     <= S_ACTIVE;
                        end else begin
                            r_ready     <= 1'b1;
                            r_err       <= 1'b1;
                            r_rdata     <= ERR_RDATA_W;
                            r_err_pulse <= 1'b1;
                            r_err_addr  <= cpu.cpu_mem_addr;
                            r_err_count <= w_err_count_next;
                            r_state     <= S_ERR;
                        end
                    end
                end
                S_ACTIVE: begin
                    if (w_sel_ready) begin
                        r_tgt_valid <= '0;
                        r_rdata     <= w_sel_rdata;
                        r_ready     <= 1'b1;
                        r_state     <= S_RESP;
                    end else if (w_timeout) begin
                        r_tgt_valid <= '0;
                        r_ready     <= 1'b1;
                        r_err       <= 1'b1;
                        r_rdata     <= ERR_RDATA_W;
                        r_err_pulse <= 1'b1;
                        r_err_addr  <= r_addr;
                        r_err_count <= w_err_count_next;
                        r_state     <= S_ERR;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_RESP:  r_state <= S_IDLE;
                S_ERR:   r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cpu.cpu_mem_ready = r_ready;
    assign cpu.cpu_mem_err   = r_err;
    assign cpu.cpu_mem_rdata = r_rdata;
    assign tgt.tgt_mem_valid = r_tgt_valid;
    assign tgt.tgt_mem_addr  = r_addr;
    assign tgt.tgt_mem_write = r_we;
    assign tgt.tgt_mem_wdata = r_wdata;
    assign tgt.tgt_mem_wstrb = r_be;
    assign err_pulse         = r_err_pulse;
    assign err_addr          = r_err_addr;
    assign err_count         = r_err_count;
endmodule

// File: tb/tb_cpu_subsys_mem_router.sv
// Directed bench for cpu_subsys_mem_router: default instance A, and instance B with
// MASK[2] widened (0xC000_0000 region unmapped) and an 8-cycle timeout.
module tb_cpu_subsys_mem_router;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        valid, sel_b, we;
    logic [31:0] addr, wdata;
    logic [3:0]  be;
    logic [7:0]  lat_a [3];
    logic [7:0]  lat_b [3];
    logic [31:0] rd_a  [3];
    logic [31:0] rd_b  [3];
    logic [7:0]  cnt_a [3];
    logic [7:0]  cnt_b [3];

    cpu_subsys_mem_router_if     #(.ADDR_W(32), .DATA_W(32)) cif_a ();
    cpu_subsys_mem_router_if     #(.ADDR_W(32), .DATA_W(32)) cif_b ();
    cpu_subsys_mem_router_tgt_if #(.N_TARGETS(3), .ADDR_W(32), .DATA_W(32)) tif_a ();
    cpu_subsys_mem_router_tgt_if #(.N_TARGETS(3), .ADDR_W(32), .DATA_W(32)) tif_b ();

    logic        err_pulse_a, err_pulse_b;
    logic [31:0] err_addr_a, err_addr_b;
    logic [15:0] err_count_a, err_count_b;

    cpu_subsys_mem_router u_dut_a (
        .sys_clk(clk), .rst(rst), .cpu(cif_a), .tgt(tif_a),
        .err_pulse(err_pulse_a), .err_addr(err_addr_a), .err_count(err_count_a)
    );

    cpu_subsys_mem_router #(
        .TARGET_MASK({32'hC000_0000, 32'hC000_0000, 32'hC000_0000}),
        .TIMEOUT_CYCLES(8)
    ) u_dut_b (
        .sys_clk(clk), .rst(rst), .cpu(cif_b), .tgt(tif_b),
        .err_pulse(err_pulse_b), .err_addr(err_addr_b), .err_count(err_count_b)
    );

    assign cif_a.cpu_mem_valid = valid & ~sel_b;
    assign cif_b.cpu_mem_valid = valid & sel_b;
    assign cif_a.cpu_mem_addr  = addr;
    assign cif_b.cpu_mem_addr  = addr;
    assign cif_a.cpu_mem_wdata = wdata;
    assign cif_b.cpu_mem_wdata = wdata;
    assign cif_a.cpu_mem_we    = we;
    assign cif_b.cpu_mem_we    = we;
    assign cif_a.cpu_mem_be    = be;
    assign cif_b.cpu_mem_be    = be;

    // Target models: ready combinationally once valid has been held for lat cycles.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            tif_a.tgt_mem_ready[i]          = tif_a.tgt_mem_valid[i] && (cnt_a[i] == lat_a[i]);
            tif_b.tgt_mem_ready[i]          = tif_b.tgt_mem_valid[i] && (cnt_b[i] == lat_b[i]);
            tif_a.tgt_mem_rdata[i*32 +: 32] = rd_a[i];
            tif_b.tgt_mem_rdata[i*32 +: 32] = rd_b[i];
        end
    end

    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                cnt_a[i] <= 8'd0;
                cnt_b[i] <= 8'd0;
            end else begin
                cnt_a[i] <= (tif_a.tgt_mem_valid[i] && !tif_a.tgt_mem_ready[i]) ? cnt_a[i] + 8'd1 : 8'd0;
                cnt_b[i] <= (tif_b.tgt_mem_valid[i] && !tif_b.tgt_mem_ready[i]) ? cnt_b[i] + 8'd1 : 8'd0;
            end
        end
    end

    logic        o_ready, o_err, o_twrite, o_epulse;
    logic [31:0] o_rdata, o_taddr, o_twdata, o_eaddr;
    logic [2:0]  o_tvalid;
    logic [3:0]  o_twstrb;
    logic [15:0] o_ecount;
    assign o_ready  = sel_b ? cif_b.cpu_mem_ready : cif_a.cpu_mem_ready;
    assign o_err    = sel_b ? cif_b.cpu_mem_err   : cif_a.cpu_mem_err;
    assign o_rdata  = sel_b ? cif_b.cpu_mem_rdata : cif_a.cpu_mem_rdata;
    assign o_tvalid = sel_b ? tif_b.tgt_mem_valid : tif_a.tgt_mem_valid;
    assign o_taddr  = sel_b ? tif_b.tgt_mem_addr  : tif_a.tgt_mem_addr;
    assign o_twrite = sel_b ? tif_b.tgt_mem_write : tif_a.tgt_mem_write;
    assign o_twdata = sel_b ? tif_b.tgt_mem_wdata : tif_a.tgt_mem_wdata;
    assign o_twstrb = sel_b ? tif_b.tgt_mem_wstrb : tif_a.tgt_mem_wstrb;
    assign o_epulse = sel_b ? err_pulse_b : err_pulse_a;
    assign o_eaddr  = sel_b ? err_addr_b  : err_addr_a;
    assign o_ecount = sel_b ? err_count_b : err_count_a;

    typedef struct packed {
        logic [31:0] rd;
        logic        err;
    } resp_t;
    resp_t sb[$];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issues one request at a negedge; exp_lat counts the valid cycle as cycle 1.
    task automatic txn(input string tag, input logic b, input logic [31:0] a, input logic w,
                       input logic [31:0] wd, input logic [3:0] s, input logic [31:0] exp_rd,
                       input logic exp_err, input int exp_lat, input int exp_vcyc,
                       input logic [2:0] exp_vmask);
        int         cyc;
        int         vcyc;
        logic [2:0] vmask;
        logic       seen;
        resp_t      r;
        sel_b = b; addr = a; we = w; wdata = wd; be = s; valid = 1'b1;
        sb.push_back('{rd: exp_rd, err: exp_err});
        cyc = 0; vcyc = 0; vmask = '0; seen = 1'b0;
        while (!seen && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (o_tvalid != 3'b000) begin
                vcyc++;
                vmask |= o_tvalid;
                if (vcyc == 1) begin
                    chk({tag, "_taddr"},  o_taddr,         a);
                    chk({tag, "_twrite"}, 32'(o_twrite),   32'(w));
                    chk({tag, "_twdata"}, o_twdata,        wd);
                    chk({tag, "_twstrb"}, 32'(o_twstrb),   32'(s));
                end
            end
            if (o_ready) seen = 1'b1;
        end
        valid = 1'b0;
        r = sb.pop_front();
        chk({tag, "_done"}, 32'(seen), 32'd1);
        if (seen) begin
            chk({tag, "_rdata"},   o_rdata,         r.rd);
            chk({tag, "_err"},     32'(o_err),      32'(r.err));
            chk({tag, "_epulse"},  32'(o_epulse),   32'(r.err));
            chk({tag, "_latency"}, 32'(cyc + 1),    32'(exp_lat));
            chk({tag, "_vcycles"}, 32'(vcyc),       32'(exp_vcyc));
            chk({tag, "_vmask"},   32'(vmask),      32'(exp_vmask));
        end
        @(negedge clk);
        chk({tag, "_ready_pulse"}, 32'(o_ready), 32'd0);
    endtask

    initial begin
        rst = 1'b1; valid = 1'b0; sel_b = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = '0;
        for (int i = 0; i < 3; i++) begin
            lat_a[i] = 8'hFF; lat_b[i] = 8'hFF; rd_a[i] = '0; rd_b[i] = '0;
        end
        repeat (2) @(negedge clk);
        chk("rst_tvalid",  32'(o_tvalid),   32'd0);
        chk("rst_ready",   32'(o_ready),    32'd0);
        chk("rst_rdata",   o_rdata,         32'd0);
        chk("rst_taddr",   o_taddr,         32'd0);
        chk("rst_ecount",  32'(err_count_b), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        lat_a[1] = 8'd1; rd_a[1] = 32'h1234_5678;
        txn("sram_rd", 1'b0, 32'h4000_0010, 1'b0, 32'h0, 4'hF, 32'h1234_5678, 1'b0, 4, 2, 3'b010);

        lat_a[2] = 8'd0; rd_a[2] = 32'h0BAD_F00D;
        txn("periph_wr", 1'b0, 32'h8000_0004, 1'b1, 32'hA5A5_A5A5, 4'b0011, 32'h0BAD_F00D, 1'b0, 3, 1, 3'b100);

        txn("miss", 1'b1, 32'hC000_0000, 1'b1, 32'h1111_2222, 4'hF, 32'hDEAD_BEEF, 1'b1, 2, 0, 3'b000);
        chk("miss_eaddr",  o_eaddr,         32'hC000_0000);
        chk("miss_ecount", 32'(o_ecount),   32'd1);

        txn("timeout", 1'b1, 32'h0000_0100, 1'b0, 32'h0, 4'hF, 32'hDEAD_BEEF, 1'b1, 10, 8, 3'b001);
        chk("timeout_eaddr",  o_eaddr,       32'h0000_0100);
        chk("timeout_ecount", 32'(o_ecount), 32'd2);

        lat_b[1] = 8'd0; rd_b[1] = 32'hCAFE_0001;
        txn("after_to", 1'b1, 32'h4000_0040, 1'b0, 32'h0, 4'hF, 32'hCAFE_0001, 1'b0, 3, 1, 3'b010);

        lat_b[0] = 8'd7; rd_b[0] = 32'h7777_0007;
        txn("rdy_at_to", 1'b1, 32'h0000_0200, 1'b0, 32'h0, 4'hF, 32'h7777_0007, 1'b0, 10, 8, 3'b001);
        chk("rdy_at_to_ecount", 32'(o_ecount), 32'd2);
        chk("rdy_at_to_eaddr",  o_eaddr,       32'h0000_0100);

        force u_dut_b.r_err_count = 16'hFFFE;
        @(negedge clk);
        release u_dut_b.r_err_count;
        txn("sat1", 1'b1, 32'hC000_0004, 1'b0, 32'h0, 4'hF, 32'hDEAD_BEEF, 1'b1, 2, 0, 3'b000);
        chk("sat1_ecount", 32'(o_ecount), 32'h0000_FFFF);
        txn("sat2", 1'b1, 32'hD000_0008, 1'b1, 32'h5, 4'h1, 32'hDEAD_BEEF, 1'b1, 2, 0, 3'b000);
        chk("sat2_ecount", 32'(o_ecount), 32'h0000_FFFF);
        txn("sat3", 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 4'hF, 32'hDEAD_BEEF, 1'b1, 2, 0, 3'b000);
        chk("sat3_ecount", 32'(o_ecount), 32'h0000_FFFF);
        chk("sat3_eaddr",  o_eaddr,       32'hFFFF_FFFC);

        // Abandon an in-flight ROM access with an asynchronous reset.
        sel_b = 1'b0; addr = 32'h0000_0100; we = 1'b0; be = 4'hF; valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("pre_rst_tvalid", 32'(o_tvalid), 32'b001);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_tvalid",  32'(o_tvalid),    32'd0);
        chk("mid_rst_taddr",   o_taddr,          32'd0);
        chk("mid_rst_ready",   32'(o_ready),     32'd0);
        chk("mid_rst_rdata",   o_rdata,          32'd0);
        chk("mid_rst_ecount",  32'(err_count_b), 32'd0);
        chk("mid_rst_eaddr",   err_addr_b,       32'd0);
        valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        lat_a[1] = 8'd0; rd_a[1] = 32'h5555_AAAA;
        txn("post_rst", 1'b0, 32'h4000_0020, 1'b0, 32'h0, 4'hF, 32'h5555_AAAA, 1'b0, 3, 1, 3'b010);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
